// File: rtl/processor_run_controller_if.sv
// Host/processor signal bundle for processor_run_controller.
// The master modport is the controller side; the slave modport is the host/processor side.
interface processor_run_controller_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 host_go;
  logic                 host_clear;
  logic                 endop_signal1;
  logic                 endop_signal2;
  logic                 core_reset;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic                 core1_done;
  logic                 core2_done;
  logic [CNT_WIDTH-1:0] cycle_count;

  modport master (
    input  host_go, host_clear, endop_signal1, endop_signal2,
    output core_reset, start, busy, done, timeout, core1_done, core2_done, cycle_count
  );

  modport slave (
    output host_go, host_clear, endop_signal1, endop_signal2,
    input  core_reset, start, busy, done, timeout, core1_done, core2_done, cycle_count
  );
endinterface

// File: rtl/processor_run_controller.sv
// Host-side reset/start/endop sequencer for the dual-core processor.
// Define RUN_CTRL_ANY_FINISH_EN to complete a run when either core ends instead of both.
module processor_run_controller #(
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  processor_run_controller_if.master   bus
);

  localparam int                   RW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0]        RST_LOAD = RW'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_VAL   = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CORE_RST = 3'd1,
    START    = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4,
    TIMEOUT  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 c1_q, c1_d, c2_q, c2_d;
  logic                 c1_nx, c2_nx, finish;

  // Run-cycle counter holds at all-ones rather than wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == {CNT_WIDTH{1'b1}}) ? c : c + CNT_WIDTH'(1);
  endfunction

  assign cnt_inc = sat_inc(cnt_q);
  assign c1_nx   = c1_q | bus.endop_signal1;
  assign c2_nx   = c2_q | bus.endop_signal2;
`ifdef RUN_CTRL_ANY_FINISH_EN
  assign finish  = c1_nx | c2_nx;
`else
  assign finish  = c1_nx & c2_nx;
`endif

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    c1_d      = c1_q;
    c2_d      = c2_q;
    case (state_q)
      IDLE: begin
        if (bus.host_go) begin
          state_d   = CORE_RST;
          rst_cnt_d = RST_LOAD;
          cnt_d     = '0;
          c1_d      = 1'b0;
          c2_d      = 1'b0;
        end
      end
      CORE_RST: begin
        if (rst_cnt_q == '0) state_d = START;
        else rst_cnt_d = rst_cnt_q - RW'(1);
      end
      START: state_d = RUN;
      RUN: begin
        cnt_d = cnt_inc;
        c1_d  = c1_nx;
        c2_d  = c2_nx;
        // Finishing on the timeout cycle still counts as a normal completion.
        if (finish) state_d = DONE;
        else if (cnt_inc == TO_VAL) state_d = TIMEOUT;
      end
      DONE, TIMEOUT: begin
        if (bus.host_go) begin
          state_d   = CORE_RST;
          rst_cnt_d = RST_LOAD;
          cnt_d     = '0;
          c1_d      = 1'b0;
          c2_d      = 1'b0;
        end else if (bus.host_clear) begin
          state_d = IDLE;
          cnt_d   = '0;
          c1_d    = 1'b0;
          c2_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
      c1_q      <= 1'b0;
      c2_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cnt_q     <= cnt_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
    end
  end

  assign bus.core_reset  = (state_q == CORE_RST);
  assign bus.start       = (state_q == START);
  assign bus.busy        = (state_q == CORE_RST) || (state_q == START) || (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.timeout     = (state_q == TIMEOUT);
  assign bus.core1_done  = c1_q;
  assign bus.core2_done  = c2_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_processor_run_controller.sv
// Directed-vector bench for processor_run_controller (RESET_CYCLES=2, TIMEOUT_CYCLES=20).
// Status vectors are {core_reset, start, busy, done, timeout, core1_done, core2_done}.
module tb_processor_run_controller;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  processor_run_controller_if #(.CNT_WIDTH(16)) bus ();

  processor_run_controller #(
    .RESET_CYCLES(2), .TIMEOUT_CYCLES(20), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st();
    return {25'd0, bus.core_reset, bus.start, bus.busy, bus.done, bus.timeout,
            bus.core1_done, bus.core2_done};
  endfunction

  function automatic logic [31:0] cnt();
    return {16'd0, bus.cycle_count};
  endfunction

  // Pulse host_go and step through the two reset cycles and the start cycle into RUN.
  task automatic launch_to_run();
    bus.host_go = 1'b1;
    tick();
    bus.host_go    = 1'b0;
    bus.host_clear = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.host_go = 1'b0;
    bus.host_clear = 1'b0;
    bus.endop_signal1 = 1'b0;
    bus.endop_signal2 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_status", st(), 32'b0000000);
    chk("reset_count", cnt(), 0);

    // Launch sequence timing
    bus.host_go = 1'b1;
    tick();
    bus.host_go = 1'b0;
    chk("core_rst_1", st(), 32'b1010000);
    tick();
    chk("core_rst_2", st(), 32'b1010000);
    tick();
    chk("start_pulse", st(), 32'b0110000);
    tick();
    chk("run_entry", st(), 32'b0010000);
    chk("run_entry_count", cnt(), 0);

`ifndef RUN_CTRL_ANY_FINISH_EN
    for (int k = 1; k <= 9; k++) begin
      bus.endop_signal1 = (k == 5);
      bus.endop_signal2 = (k == 9);
      tick();
      if (k == 4) chk("c1_before_5", st(), 32'b0010000);
      if (k == 5) begin
        chk("c1_set_at_5", st(), 32'b0010010);
        chk("count_at_5", cnt(), 5);
      end
    end
    bus.endop_signal1 = 1'b0;
    bus.endop_signal2 = 1'b0;
    chk("done_both", st(), 32'b0001011);
    chk("done_count", cnt(), 9);
    tick();
    chk("done_hold", st(), 32'b0001011);
    chk("done_hold_count", cnt(), 9);
`else
    for (int k = 1; k <= 4; k++) begin
      bus.endop_signal2 = (k == 4);
      tick();
      if (k == 3) chk("any_pre", st(), 32'b0010000);
    end
    bus.endop_signal2 = 1'b0;
    chk("any_done_c2", st(), 32'b0001001);
    chk("any_done_count", cnt(), 4);
    tick();
    chk("any_done_hold", cnt(), 4);
`endif

    // host_go and host_clear together relaunch and clear status
    bus.host_go = 1'b1;
    bus.host_clear = 1'b1;
    tick();
    bus.host_go = 1'b0;
    bus.host_clear = 1'b0;
    chk("relaunch_status", st(), 32'b1010000);
    chk("relaunch_count", cnt(), 0);
    tick();
    tick();
    tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 19) begin
        chk("pre_timeout", st(), 32'b0010000);
        chk("pre_timeout_count", cnt(), 19);
      end
    end
    chk("timeout_status", st(), 32'b0000100);
    chk("timeout_count", cnt(), 20);
    tick();
    chk("timeout_hold", cnt(), 20);

    // host_clear returns to IDLE; endop held outside RUN is not latched
    bus.host_clear = 1'b1;
    tick();
    bus.host_clear = 1'b0;
    chk("clear_status", st(), 32'b0000000);
    chk("clear_count", cnt(), 0);
    bus.endop_signal1 = 1'b1;
    tick();
    chk("idle_no_latch", st(), 32'b0000000);
    bus.host_go = 1'b1;
    tick();
    bus.host_go = 1'b0;
    chk("crst_no_latch", st(), 32'b1010000);
    tick();
    tick();
    chk("start_no_latch", st(), 32'b0110000);
    tick();
    chk("run0_no_latch", st(), 32'b0010000);
    tick();
`ifndef RUN_CTRL_ANY_FINISH_EN
    chk("run1_latched", st(), 32'b0010010);
    chk("run1_count", cnt(), 1);
    for (int k = 2; k <= 20; k++) begin
      bus.endop_signal2 = (k == 20);
      tick();
    end
    bus.endop_signal1 = 1'b0;
    bus.endop_signal2 = 1'b0;
    chk("finish_beats_timeout", st(), 32'b0001011);
    chk("finish_at_20_count", cnt(), 20);
`else
    bus.endop_signal1 = 1'b0;
    chk("any_done_c1", st(), 32'b0001010);
    chk("any_done_c1_count", cnt(), 1);
`endif

    // Reset in RUN cycle 3 aborts the run
    launch_to_run();
    tick();
    tick();
    chk("abort_pre_count", cnt(), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_status", st(), 32'b0000000);
    chk("abort_count", cnt(), 0);
    tick();
    chk("abort_idle_hold", st(), 32'b0000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
